counter_job_arbiter: RTL and testbench

//   Shares one loadable up-counter (the CounterUp block) between two requesters.

---
 rtl/counter_job_arbiter_pkg.sv | 26 ++
 rtl/counter_job_arbiter_rr.sv | 47 ++++
 rtl/counter_job_arbiter.sv | 155 +++++++++++++++
 tb/tb_counter_job_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_job_arbiter_pkg.sv
// Shared definitions for the counter job arbiter: FSM states, requester
// indices and the values the outputs take while in reset.
package counter_job_arbiter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_COUNT,
      ST_READ,
      ST_DONE
   } state_e;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

   localparam logic [1:0] RST_GRANT  = 2'b00;
   localparam logic       RST_LOAD_N = 1'b1;
   localparam logic       RST_ENABLE = 1'b0;
   localparam logic       RST_OE_N   = 1'b1;

   // Converts a requester index into its one-hot grant vector.
   function automatic logic [1:0] oneHot2(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/counter_job_arbiter_rr.sv
// Two-way round-robin arbiter. On a tie the requester that was not served
// last wins; the pointer only moves when the owner accepts a grant.
module rr_arbiter2
   import counter_job_arbiter_pkg::*;
(
   input  logic       Clk,
   input  logic       Reset,
   input  logic [1:0] Req,
   input  logic       Accept,
   output logic [1:0] GrantOneHot,
   output logic       Pointer
);

   logic pointer_q;
   logic pointer_d;

   // Pick the winner for the current request pattern.
   always_comb begin
      GrantOneHot = 2'b00;
      case (Req)
         2'b01:   GrantOneHot = oneHot2(REQ0);
         2'b10:   GrantOneHot = oneHot2(REQ1);
         2'b11:   GrantOneHot = oneHot2(pointer_q);
         default: GrantOneHot = 2'b00;
      endcase
   end

   // After a grant is taken, hand priority to the other requester.
   always_comb begin
      pointer_d = pointer_q;
      if (Accept && (GrantOneHot != 2'b00)) begin
         pointer_d = GrantOneHot[0] ? REQ1 : REQ0;
      end
   end

   // Priority pointer register; reset favours requester 0.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         pointer_q <= REQ0;
      end else begin
         pointer_q <= pointer_d;
      end
   end

   assign Pointer = pointer_q;

endmodule

// File: rtl/counter_job_arbiter.sv
// Shares one external loadable up-counter between two requesters. A job is
// load start, count N steps, read the counter back, then pulse Done to the owner.
module counter_job_arbiter
   import counter_job_arbiter_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int STEPW = 8
)
(
   input  logic             Clk,
   input  logic             Reset,
   input  logic [1:0]       Req,
   input  logic [WIDTH-1:0] Start0,
   input  logic [WIDTH-1:0] Start1,
   input  logic [STEPW-1:0] Steps0,
   input  logic [STEPW-1:0] Steps1,
   output logic [1:0]       Grant,
   output logic [1:0]       Done,
   output logic [WIDTH-1:0] Result,
   output logic             Result_Valid,
   output logic [WIDTH-1:0] CntD,
   output logic             CntLoad_n,
   output logic             CntEnable,
   output logic             CntOE_n,
   input  logic [WIDTH-1:0] CntQ
);

   state_e           state_q, state_d;
   logic [1:0]       grant_q, grant_d;
   logic [1:0]       done_q, done_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] cntD_q, cntD_d;
   logic             loadN_q, loadN_d;
   logic             enable_q, enable_d;
   logic             oeN_q, oeN_d;
   logic [STEPW-1:0] stepCnt_q, stepCnt_d;

   logic             accept;
   logic [1:0]       arbGrant;
   logic             rrPointer;
   logic             winnerIdx;

   rr_arbiter2 u_rr (
      .Clk         (Clk),
      .Reset       (Reset),
      .Req         (Req),
      .Accept      (accept),
      .GrantOneHot (arbGrant),
      .Pointer     (rrPointer)
   );

   // Index of the winning requester, used to steer its job fields in.
   always_comb begin
      winnerIdx = (Req == 2'b11) ? rrPointer : Req[1];
   end

   // Job sequencer: next state plus the next value of every registered output.
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      done_d    = 2'b00;
      result_d  = result_q;
      valid_d   = 1'b0;
      cntD_d    = cntD_q;
      loadN_d   = loadN_q;
      enable_d  = enable_q;
      oeN_d     = oeN_q;
      stepCnt_d = stepCnt_q;
      accept    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (Req != 2'b00) begin
               accept    = 1'b1;
               grant_d   = arbGrant;
               cntD_d    = (winnerIdx == REQ1) ? Start1 : Start0;
               stepCnt_d = (winnerIdx == REQ1) ? Steps1 : Steps0;
               loadN_d   = 1'b0;
               state_d   = ST_LOAD;
            end
         end
         ST_LOAD: begin
            loadN_d = 1'b1;
            if (stepCnt_q == '0) begin
               oeN_d   = 1'b0;
               state_d = ST_READ;
            end else begin
               enable_d = 1'b1;
               state_d  = ST_COUNT;
            end
         end
         ST_COUNT: begin
            if (stepCnt_q == STEPW'(1)) begin
               stepCnt_d = '0;
               enable_d  = 1'b0;
               oeN_d     = 1'b0;
               state_d   = ST_READ;
            end else begin
               stepCnt_d = stepCnt_q - STEPW'(1);
            end
         end
         ST_READ: begin
            result_d = CntQ;
            oeN_d    = 1'b1;
            done_d   = grant_q;
            valid_d  = 1'b1;
            state_d  = ST_DONE;
         end
         ST_DONE: begin
            grant_d = 2'b00;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any job immediately.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q   <= ST_IDLE;
         grant_q   <= RST_GRANT;
         done_q    <= 2'b00;
         result_q  <= '0;
         valid_q   <= 1'b0;
         cntD_q    <= '0;
         loadN_q   <= RST_LOAD_N;
         enable_q  <= RST_ENABLE;
         oeN_q     <= RST_OE_N;
         stepCnt_q <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         done_q    <= done_d;
         result_q  <= result_d;
         valid_q   <= valid_d;
         cntD_q    <= cntD_d;
         loadN_q   <= loadN_d;
         enable_q  <= enable_d;
         oeN_q     <= oeN_d;
         stepCnt_q <= stepCnt_d;
      end
   end

   assign Grant        = grant_q;
   assign Done         = done_q;
   assign Result       = result_q;
   assign Result_Valid = valid_q;
   assign CntD         = cntD_q;
   assign CntLoad_n    = loadN_q;
   assign CntEnable    = enable_q;
   assign CntOE_n      = oeN_q;

endmodule

// File: tb/tb_counter_job_arbiter.sv
// Directed bench for counter_job_arbiter, with a behavioural CounterUp
// (sync active-low load, active-high enable, tri-stated output).
module tb_counter_job_arbiter;

   logic       Clk = 1'b0;
   logic       Reset;
   logic [1:0] Req;
   logic [7:0] Start0, Start1, Steps0, Steps1;
   logic [1:0] Grant, Done;
   logic [7:0] Result, CntD;
   logic       Result_Valid, CntLoad_n, CntEnable, CntOE_n;
   wire  [7:0] CntQ;
   logic [7:0] counterValue = 8'h00;

   int checks = 0;
   int passes = 0;

   counter_job_arbiter #(.WIDTH(8), .STEPW(8)) dut (
      .Clk(Clk), .Reset(Reset), .Req(Req),
      .Start0(Start0), .Start1(Start1), .Steps0(Steps0), .Steps1(Steps1),
      .Grant(Grant), .Done(Done), .Result(Result), .Result_Valid(Result_Valid),
      .CntD(CntD), .CntLoad_n(CntLoad_n), .CntEnable(CntEnable), .CntOE_n(CntOE_n),
      .CntQ(CntQ)
   );

   // Free-running clock.
   always #5 Clk = ~Clk;

   // CounterUp model: its own reset is held inactive, so only load and enable act.
   always @(posedge Clk) begin
      if (!CntLoad_n) counterValue <= CntD;
      else if (CntEnable) counterValue <= counterValue + 8'd1;
   end

   assign CntQ = CntOE_n ? 8'hzz : counterValue;

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   // Follows one job from Grant to Done. latency counts the Grant cycle as 1.
   task automatic observeJob(input bit disturb, output logic [1:0] gVal, output int latency,
                             output int enCount, output logic [1:0] doneVal, output logic [7:0] resVal,
                             output logic validVal, output logic validAfter, output logic [1:0] doneAfter,
                             output logic [1:0] grantAfter, output int waitCycles, output bit timedOut);
      timedOut = 1'b0; waitCycles = 0; gVal = 2'b00; latency = 0; enCount = 0; doneVal = 2'b00;
      resVal = 8'h00; validVal = 1'b0; validAfter = 1'b0; doneAfter = 2'b00; grantAfter = 2'b00;
      while (Grant == 2'b00 && waitCycles < 40) begin
         step();
         waitCycles++;
      end
      if (Grant == 2'b00) begin
         timedOut = 1'b1;
         return;
      end
      gVal = Grant;
      latency = 1;
      while (Done == 2'b00 && latency < 300) begin
         if (CntEnable) enCount++;
         if (disturb && latency == 2) begin
            Req = 2'b00; Start0 = 8'h77; Steps0 = 8'h55; Start1 = 8'h66; Steps1 = 8'h44;
         end
         step();
         latency++;
      end
      if (Done == 2'b00) begin
         timedOut = 1'b1;
         return;
      end
      doneVal = Done; resVal = Result; validVal = Result_Valid;
      step();
      validAfter = Result_Valid; doneAfter = Done; grantAfter = Grant;
   endtask

   logic [1:0] gVal, doneVal, doneAfter, grantAfter;
   logic [7:0] resVal;
   logic       validVal, validAfter;
   int         latency, enCount, waitCycles;
   bit         timedOut;

   task automatic test_reset();
      Reset = 1'b1; Req = 2'b00;
      Start0 = 8'h00; Start1 = 8'h00; Steps0 = 8'h00; Steps1 = 8'h00;
      step(); step();
      checks++;
      if ({Grant, Done, Result, Result_Valid} !== {2'b00, 2'b00, 8'h00, 1'b0})
         $display("[TB] FAIL reset_outputs: got %b %b %h %b want 00 00 00 0", Grant, Done, Result, Result_Valid);
      else passes++;
      checks++;
      if ({CntD, CntLoad_n, CntEnable, CntOE_n} !== {8'h00, 1'b1, 1'b0, 1'b1})
         $display("[TB] FAIL reset_counter_strobes: got %h %b %b %b want 00 1 0 1", CntD, CntLoad_n, CntEnable, CntOE_n);
      else passes++;
      Reset = 1'b0;
      step();
      checks++;
      if (Grant !== 2'b00) $display("[TB] FAIL idle_no_grant: got %b want 00", Grant);
      else passes++;
   endtask

   task automatic test_single_job();
      Req = 2'b01; Start0 = 8'h05; Steps0 = 8'h0A;
      observeJob(1'b0, gVal, latency, enCount, doneVal, resVal, validVal, validAfter, doneAfter, grantAfter, waitCycles, timedOut);
      Req = 2'b00;
      checks++;
      if (timedOut) $display("[TB] FAIL single_timeout: job did not complete want Done");
      else passes++;
      checks++;
      if (gVal !== 2'b01) $display("[TB] FAIL single_grant: got %b want 01", gVal);
      else passes++;
      checks++;
      if (enCount != 10) $display("[TB] FAIL single_enable_cycles: got %0d want 10", enCount);
      else passes++;
      checks++;
      if (latency != 13) $display("[TB] FAIL single_latency: got %0d want 13", latency);
      else passes++;
      checks++;
      if ({doneVal, resVal, validVal} !== {2'b01, 8'h0F, 1'b1})
         $display("[TB] FAIL single_result: got %b %h %b want 01 0f 1", doneVal, resVal, validVal);
      else passes++;
      checks++;
      if ({grantAfter, doneAfter, validAfter} !== {2'b00, 2'b00, 1'b0})
         $display("[TB] FAIL single_release: got %b %b %b want 00 00 0", grantAfter, doneAfter, validAfter);
      else passes++;
   endtask

   task automatic test_zero_steps();
      Req = 2'b10; Start1 = 8'h42; Steps1 = 8'h00;
      observeJob(1'b0, gVal, latency, enCount, doneVal, resVal, validVal, validAfter, doneAfter, grantAfter, waitCycles, timedOut);
      Req = 2'b00;
      checks++;
      if (timedOut || gVal !== 2'b10) $display("[TB] FAIL zero_grant: got %b timeout %0d want 10", gVal, timedOut);
      else passes++;
      checks++;
      if (enCount != 0) $display("[TB] FAIL zero_enable_cycles: got %0d want 0", enCount);
      else passes++;
      checks++;
      if (latency != 3) $display("[TB] FAIL zero_latency: got %0d want 3", latency);
      else passes++;
      checks++;
      if ({doneVal, resVal} !== {2'b10, 8'h42}) $display("[TB] FAIL zero_result: got %b %h want 10 42", doneVal, resVal);
      else passes++;
   endtask

   task automatic test_tie_rr();
      Req = 2'b11; Start0 = 8'h10; Start1 = 8'h20; Steps0 = 8'h03; Steps1 = 8'h03;
      observeJob(1'b0, gVal, latency, enCount, doneVal, resVal, validVal, validAfter, doneAfter, grantAfter, waitCycles, timedOut);
      Req = 2'b10;
      checks++;
      if (timedOut || {gVal, doneVal, resVal} !== {2'b01, 2'b01, 8'h13})
         $display("[TB] FAIL tie_first: got %b %b %h want 01 01 13", gVal, doneVal, resVal);
      else passes++;
      observeJob(1'b0, gVal, latency, enCount, doneVal, resVal, validVal, validAfter, doneAfter, grantAfter, waitCycles, timedOut);
      Req = 2'b00;
      checks++;
      if (timedOut || {gVal, doneVal, resVal} !== {2'b10, 2'b10, 8'h23})
         $display("[TB] FAIL tie_second: got %b %b %h want 10 10 23", gVal, doneVal, resVal);
      else passes++;
   endtask

   task automatic test_wrap();
      Req = 2'b01; Start0 = 8'hFE; Steps0 = 8'h03;
      observeJob(1'b1, gVal, latency, enCount, doneVal, resVal, validVal, validAfter, doneAfter, grantAfter, waitCycles, timedOut);
      Req = 2'b00;
      checks++;
      if (timedOut || {doneVal, resVal, validVal} !== {2'b01, 8'h01, 1'b1})
         $display("[TB] FAIL wrap_result: got %b %h %b want 01 01 1", doneVal, resVal, validVal);
      else passes++;
      checks++;
      if (latency != 6 || enCount != 3) $display("[TB] FAIL wrap_timing: got lat %0d en %0d want 6 3", latency, enCount);
      else passes++;
      checks++;
      if ({validAfter, doneAfter} !== {1'b0, 2'b00}) $display("[TB] FAIL wrap_single_pulse: got %b %b want 0 00", validAfter, doneAfter);
      else passes++;
   endtask

   task automatic test_back_to_back();
      Req = 2'b11; Start0 = 8'h10; Start1 = 8'h20; Steps0 = 8'h03; Steps1 = 8'h03;
      observeJob(1'b0, gVal, latency, enCount, doneVal, resVal, validVal, validAfter, doneAfter, grantAfter, waitCycles, timedOut);
      checks++;
      if (timedOut || {gVal, resVal} !== {2'b10, 8'h23}) $display("[TB] FAIL b2b_first: got %b %h want 10 23", gVal, resVal);
      else passes++;
      checks++;
      if (grantAfter !== 2'b00) $display("[TB] FAIL b2b_idle_gap: got grant %b want 00", grantAfter);
      else passes++;
      observeJob(1'b0, gVal, latency, enCount, doneVal, resVal, validVal, validAfter, doneAfter, grantAfter, waitCycles, timedOut);
      Req = 2'b00;
      checks++;
      if (timedOut || {gVal, resVal} !== {2'b01, 8'h13}) $display("[TB] FAIL b2b_second: got %b %h want 01 13", gVal, resVal);
      else passes++;
      checks++;
      if (waitCycles != 1) $display("[TB] FAIL b2b_restart: got %0d idle cycles want 1", waitCycles);
      else passes++;
   endtask

   task automatic test_reset_mid_job();
      int waitCnt;
      Req = 2'b01; Start0 = 8'h30; Steps0 = 8'h08;
      waitCnt = 0;
      while (Grant == 2'b00 && waitCnt < 40) begin
         step();
         waitCnt++;
      end
      step(); step(); step();
      checks++;
      if (CntEnable !== 1'b1 || Grant !== 2'b01) $display("[TB] FAIL midreset_counting: got en %b grant %b want 1 01", CntEnable, Grant);
      else passes++;
      Reset = 1'b1;
      #1;
      checks++;
      if ({Grant, Done, Result, Result_Valid, CntD, CntLoad_n, CntEnable, CntOE_n} !==
          {2'b00, 2'b00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1})
         $display("[TB] FAIL midreset_outputs: got %b %b %h %b %h %b %b %b want 00 00 00 0 00 1 0 1",
                  Grant, Done, Result, Result_Valid, CntD, CntLoad_n, CntEnable, CntOE_n);
      else passes++;
      Req = 2'b00;
      step(); step();
      Reset = 1'b0;
      step(); step();
      checks++;
      if ({Grant, Done} !== 4'b0000) $display("[TB] FAIL midreset_no_done: got %b %b want 00 00", Grant, Done);
      else passes++;
      Req = 2'b01; Start0 = 8'h00; Steps0 = 8'h02;
      observeJob(1'b0, gVal, latency, enCount, doneVal, resVal, validVal, validAfter, doneAfter, grantAfter, waitCycles, timedOut);
      Req = 2'b00;
      checks++;
      if (timedOut || {gVal, doneVal, resVal} !== {2'b01, 2'b01, 8'h02})
         $display("[TB] FAIL midreset_reload: got %b %b %h want 01 01 02", gVal, doneVal, resVal);
      else passes++;
      checks++;
      if (latency != 5) $display("[TB] FAIL midreset_latency: got %0d want 5", latency);
      else passes++;
   endtask

   // Scenario sequence; the round-robin pointer carries over between tasks.
   initial begin
      test_reset();
      test_single_job();
      test_zero_steps();
      test_tie_rr();
      test_wrap();
      test_back_to_back();
      test_reset_mid_job();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
